// File: rtl/ysyx_22050612_ifu_pkg.sv
// ysyx_22050612_ifu_pkg: shared FSM states and constants for the instruction fetch unit
package ysyx_22050612_ifu_pkg;
  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    VALID    = 2'd2,
    WAIT_PC  = 2'd3
  } ifu_state_e;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/ysyx_22050612_ifu.sv
// ysyx_22050612_ifu: non-pipelined fetch, one instruction per dnpc over a 64-bit request/response bus
module ysyx_22050612_ifu
  import ysyx_22050612_ifu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              dnpc_valid,
  input  logic [ADDR_W-1:0] dnpc,
  output logic [ADDR_W-1:0] pc
);
  ifu_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next, r_inst_pc;
  logic [31:0]       r_inst, w_inst_d;
  logic              r_fault, w_fault_d, w_load, r_req_valid, w_mis;
  assign w_mis = r_pc[1:0] != 2'b00;
  always_comb begin
    w_next    = r_state;
    w_pc_next = r_pc;
    w_load    = 1'b0;
    w_inst_d  = NOP;
    w_fault_d = 1'b0;
    unique case (r_state)
      FETCH: begin
        if (w_mis) begin
          w_next    = VALID;
          w_load    = 1'b1;
          w_fault_d = 1'b1;
        end else if (r_req_valid && mem_req_ready) w_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          w_next    = VALID;
          w_load    = 1'b1;
          w_fault_d = mem_rsp_err;
          w_inst_d  = mem_rsp_err ? NOP : (r_pc[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0]);
        end
      end
      VALID: begin
        if (inst_ready) begin
          w_next    = dnpc_valid ? FETCH : WAIT_PC;
          w_pc_next = dnpc_valid ? dnpc : r_pc;
        end
      end
      WAIT_PC: begin
        if (dnpc_valid) begin
          w_next    = FETCH;
          w_pc_next = dnpc;
        end
      end
      default: w_next = FETCH;
    endcase
  end
  // request valid is registered off the next pc so it never rises for a misaligned target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_inst      <= NOP;
      r_inst_pc   <= RESET_PC;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pc        <= w_pc_next;
      r_req_valid <= (w_next == FETCH) && (w_pc_next[1:0] == 2'b00);
      if (w_load) begin
        r_inst    <= w_inst_d;
        r_inst_pc <= r_pc;
        r_fault   <= w_fault_d;
      end
    end
  end
  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = {r_pc[ADDR_W-1:3], 3'b000};
  assign inst_valid    = r_state == VALID;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign inst_fault    = r_fault;
  assign pc            = r_pc;
endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// tb_ysyx_22050612_ifu: scoreboard bench driving a behavioural memory and EXU around the fetch unit
module tb_ysyx_22050612_ifu;
  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
  } exp_t;
  logic        clk = 0, rst = 1;
  logic        mem_req_valid, mem_req_ready = 0, mem_rsp_valid = 0, mem_rsp_err = 0;
  logic [63:0] mem_req_addr, mem_rsp_data = 0, inst_pc, dnpc = 0, pc;
  logic        inst_valid, inst_ready = 0, inst_fault, dnpc_valid = 0;
  logic [31:0] inst;
  exp_t        q[$];
  exp_t        cur;
  int          total = 0, bad = 0;
  ysyx_22050612_ifu dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .dnpc_valid(dnpc_valid), .dnpc(dnpc), .pc(pc)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] mem_data(input logic [63:0] a);
    return a == RST_PC ? 64'h00100093_00000513 : {a[31:0] ^ 32'hCAFE_0000, a[31:0] ^ 32'h0000_BEEF};
  endfunction
  task automatic check_out;
    if (q.size() == 0) chk("sb_empty", 1, 0);
    else begin
      cur = q.pop_front();
      chk("inst", inst, cur.inst);
      chk("inst_pc", inst_pc, cur.pc);
      chk("inst_fault", inst_fault, cur.fault);
    end
  endtask
  task automatic wait_req;
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      tick;
      n++;
    end
    chk("req_valid", mem_req_valid, 1);
  endtask
  task automatic fetch(input logic [63:0] epc, input int stall, input int rsp_delay, input bit err);
    logic [63:0] a, d;
    a = {epc[63:3], 3'b000};
    wait_req;
    chk("req_addr", mem_req_addr, a);
    repeat (stall) begin
      tick;
      chk("req_hold_v", mem_req_valid, 1);
      chk("req_hold_a", mem_req_addr, a);
      chk("stall_no_inst", inst_valid, 0);
    end
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0;
    chk("req_drop", mem_req_valid, 0);
    repeat (rsp_delay) begin
      dnpc_valid = 1;
      dnpc = 64'h1234_5678;
      tick;
      dnpc_valid = 0;
      chk("dnpc_ignored_pc", pc, epc);
      chk("dnpc_ignored_iv", inst_valid, 0);
    end
    d = mem_data(a);
    mem_rsp_valid = 1;
    mem_rsp_data = d;
    mem_rsp_err = err;
    q.push_back('{err ? NOP_W : (epc[2] ? d[63:32] : d[31:0]), epc, err});
    tick;
    mem_rsp_valid = 0;
    mem_rsp_err = 0;
    chk("inst_valid", inst_valid, 1);
    check_out;
  endtask
  task automatic misfetch(input logic [63:0] epc);
    q.push_back('{NOP_W, epc, 1'b1});
    chk("mis_no_req", mem_req_valid, 0);
    tick;
    chk("mis_no_req2", mem_req_valid, 0);
    chk("mis_valid", inst_valid, 1);
    check_out;
  endtask
  task automatic retire(input int hold, input bit same, input logic [63:0] npc);
    repeat (hold) begin
      dnpc_valid = 1;
      dnpc = 64'hDEAD_0000;
      tick;
      dnpc_valid = 0;
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", inst, cur.inst);
      chk("hold_pc", inst_pc, cur.pc);
    end
    inst_ready = 1;
    dnpc_valid = same;
    dnpc = npc;
    tick;
    inst_ready = 0;
    dnpc_valid = 0;
    chk("retire_iv", inst_valid, 0);
    if (!same) begin
      chk("wait_pc_hold", pc, cur.pc);
      mem_rsp_valid = 1;
      mem_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
      tick;
      mem_rsp_valid = 0;
      chk("spur_rsp_iv", inst_valid, 0);
      chk("spur_rsp_pc", pc, cur.pc);
      dnpc_valid = 1;
      dnpc = npc;
      tick;
      dnpc_valid = 0;
    end
    chk("new_pc", pc, npc);
    chk("dnpc_to_req", mem_req_valid, npc[1:0] == 2'b00);
  endtask
  task automatic chk_reset;
    chk("rst_req", mem_req_valid, 0);
    chk("rst_iv", inst_valid, 0);
    chk("rst_inst", inst, NOP_W);
    chk("rst_ipc", inst_pc, RST_PC);
    chk("rst_fault", inst_fault, 0);
    chk("rst_pc", pc, RST_PC);
  endtask
  initial begin
    tick;
    tick;
    chk_reset;
    rst = 0;
    fetch(RST_PC, 0, 0, 0);
    retire(0, 1, 64'h8000_0004);
    fetch(64'h8000_0004, 5, 0, 0);
    retire(3, 0, 64'h8000_0008);
    fetch(64'h8000_0008, 0, 2, 0);
    retire(0, 1, 64'h8000_0002);
    misfetch(64'h8000_0002);
    retire(1, 0, 64'h8000_0010);
    fetch(64'h8000_0010, 0, 0, 1);
    retire(1, 1, 64'h8000_0014);
    wait_req;
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0;
    #3 rst = 1;
    #1 chk_reset;
    tick;
    rst = 0;
    fetch(RST_PC, 1, 0, 0);
    retire(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
    retire(0, 1, 64'h0);
    fetch(64'h0, 0, 0, 0);
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
